div_radix2: RTL and testbench

DIV_RADIX2 -- requirements
Module: div_radix2

---
 rtl/div_radix2.sv | 126 ++++++++++++
 tb/tb_div_radix2.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - restoring radix-2 integer divider, 32 cycles per quotient, signed/unsigned
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        valid,
  input  logic        sign,
  output logic        stall,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ON   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvs;
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_diff;
  logic        w_borrow;
  logic [32:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_abs_a = (sign && a[31]) ? (32'd0 - a) : a;
  assign w_abs_b = (sign && b[31]) ? (32'd0 - b) : b;

  // r_quo starts as the dividend magnitude; its MSB shifts into the partial remainder.
  assign w_diff    = {r_rem, r_quo[31]} - {2'b00, r_dvs};
  assign w_borrow  = w_diff[33];
  assign w_rem_nxt = w_borrow ? {r_rem[31:0], r_quo[31]} : w_diff[32:0];
  assign w_quo_nxt = {r_quo[30:0], ~w_borrow};
  assign w_quo_fix = r_neg_q ? (32'd0 - w_quo_nxt) : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? (32'd0 - w_rem_nxt[31:0]) : w_rem_nxt[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (valid) begin
          w_state_nxt = (b == 32'd0) ? ZERO : ON;
        end
      end
      ZERO: w_state_nxt = DONE;
      ON: begin
        if (r_cnt == 5'd31) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 5'd0;
      r_dvs    <= 32'd0;
      r_rem    <= 33'd0;
      r_quo    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 64'd0;
    end else if (flush) begin
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_cnt   <= 5'd0;
            r_dvs   <= w_abs_b;
            r_quo   <= w_abs_a;
            r_rem   <= 33'd0;
            r_neg_q <= sign & (a[31] ^ b[31]);
            r_neg_r <= sign & a[31];
          end
        end
        ZERO: begin
          r_result <= 64'd0;
        end
        ON: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= {w_rem_fix, w_quo_fix};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready  = (r_state == DONE);
  assign stall  = valid & ~ready & ~flush;
  assign result = r_result;

endmodule

// File: tb/tb_div_radix2.sv
// tb/tb_div_radix2.sv - randomized self-checking bench for div_radix2 against an arithmetic model
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid;
  logic        sign;
  logic        stall;
  logic        ready;
  logic [63:0] result;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_res = 64'd0;

  div_radix2 dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .sign   (sign),
    .stall  (stall),
    .ready  (ready),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] mx, my, q, r;
    if (y == 32'd0) return 64'd0;
    mx = (s && x[31]) ? 32'd0 - x : x;
    my = (s && y[31]) ? 32'd0 - y : y;
    q  = mx / my;
    r  = mx % my;
    if (s && (x[31] != y[31])) q = 32'd0 - q;
    if (s && x[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_b, input logic ts,
                         input logic [63:0] exp, input string tag);
    int nst;
    logic seen;
    nst  = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tb_b; sign = ts; valid = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        chk({tag, "_res"}, result, exp);
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
      end else begin
        if (stall) nst++;
        @(posedge clk); #1;
        a = $urandom; b = $urandom; sign = 1'($urandom);
      end
    end
    valid = 1'b0;
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_nstall"}, 64'(nst), (tb_b == 32'd0) ? 64'd2 : 64'd33);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(ready), 64'd0);
    last_res = exp;
  endtask

  initial begin
    int nrdy;
    logic [31:0] ra, rb;
    logic rs;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; sign = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res", result, 64'd0);
    chk("rst_rdy", 64'(ready), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    run_div(32'h64, 32'h7, 1'b0, 64'h00000002_0000000E, "u100_7");
    run_div(32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "sm7_2");
    run_div(32'h7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "s7_m2");
    run_div(32'h1234, 32'h0, 1'b0, 64'h0, "dz");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "s_ovf");
    run_div(32'hFFFFFFFF, 32'h1, 1'b0, 64'h00000000_FFFFFFFF, "u_max");

    // flush and valid together in IDLE must not start anything
    @(posedge clk); #1;
    a = 32'd50; b = 32'd5; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("fv_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    nrdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    chk("fv_noacc", 64'(nrdy), 64'd0);

    // flush at iteration 10
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; sign = 1'b0; valid = 1'b1;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1; valid = 1'b0;
    @(negedge clk);
    chk("fl_stall", 64'(stall), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_rdy", 64'(ready), 64'd0);
    chk("fl_stall2", 64'(stall), 64'd0);
    chk("fl_res", result, last_res);
    run_div(32'd1000, 32'd3, 1'b0, ref_div(32'd1000, 32'd3, 1'b0), "fl_after");

    // reset at iteration 20
    @(posedge clk); #1;
    a = 32'hDEADBEEF; b = 32'h1234; sign = 1'b0; valid = 1'b1;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("rm_res", result, 64'd0);
    chk("rm_rdy", 64'(ready), 64'd0);
    chk("rm_stall", 64'(stall), 64'd0);
    nrdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    chk("rm_nopulse", 64'(nrdy), 64'd0);
    last_res = 64'd0;

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = rb >> $urandom_range(16, 31);
        2: ra = ra >> $urandom_range(0, 31);
        default: ;
      endcase
      run_div(ra, rb, rs, ref_div(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
